// File: rtl/aud_player.sv
// aud_player: I2S transmitter for the WM8731 DAC with a one-sample holding buffer, clocked on falling BCLK.
// Optional build macro AUD_PLAYER_HOLD_LAST_EN: an underflowing channel repeats its last loaded word instead of zeros.
module aud_player #(
    parameter int WIDTH  = 16,
    parameter int STEREO = 0,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_lrc,
    input  logic [WIDTH-1:0] i_sample,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_dacdat,
    output logic             o_active,
    output logic             o_underflow,
    output logic [CNT_W-1:0] o_underflow_cnt
);
    localparam int BCNT_W = $clog2(WIDTH + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH);
    localparam bit IS_STEREO = (STEREO != 32'sd0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              lrc_q_r;
    logic [WIDTH-1:0]  buf_r;
    logic              buf_full_r, buf_full_s;
    logic [WIDTH-1:0]  shift_r, shift_s;
    logic [WIDTH-1:0]  mono_word_r;
    logic [BCNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic              dacdat_s, active_s;
    logic [CNT_W-1:0]  uf_cnt_s;
    logic              left_start_s, right_start_s, start_s;
    logic              consume_s, take_buf_s, underflow_s, write_s;
    logic [WIDTH-1:0]  word_s, fallback_s;

    assign left_start_s  = lrc_q_r & ~i_lrc;
    assign right_start_s = ~lrc_q_r & i_lrc;
    assign o_ready       = ~buf_full_r;
    assign write_s       = i_valid & ~buf_full_r;

`ifdef AUD_PLAYER_HOLD_LAST_EN
    logic [WIDTH-1:0] last_l_r, last_r_r;

    // Remember the most recent word taken from the buffer for each channel
    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_l_r <= {WIDTH{1'b0}};
            last_r_r <= {WIDTH{1'b0}};
        end else if (take_buf_s) begin
            if (IS_STEREO && right_start_s) begin
                last_r_r <= buf_r;
            end else begin
                last_l_r <= buf_r;
            end
        end
    end

    assign fallback_s = (IS_STEREO && right_start_s) ? last_r_r : last_l_r;
`else
    assign fallback_s = {WIDTH{1'b0}};
`endif

    // Next-state logic; start_s flags entry into a shift state on this edge
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (left_start_s && i_en) begin
                    state_s = SHIFT_L;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT_L, SHIFT_R, GAP: begin
                if (left_start_s) begin
                    if (i_en) begin
                        state_s = SHIFT_L;
                        start_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (right_start_s) begin
                    state_s = SHIFT_R;
                    start_s = 1'b1;
                end else if ((state_r != GAP) && (bit_cnt_r == LAST_BIT)) begin
                    state_s = GAP;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
                start_s = 1'b0;
            end
        endcase
    end

    // Pick the word for a starting channel; buffer state is judged before this edge's write
    always_comb begin
        consume_s   = start_s && (IS_STEREO || left_start_s);
        take_buf_s  = consume_s && buf_full_r;
        underflow_s = consume_s && !buf_full_r;
        if (take_buf_s) begin
            word_s = buf_r;
        end else if (consume_s) begin
            word_s = fallback_s;
        end else begin
            word_s = mono_word_r;
        end
    end

    // Shifter, bit counter and serial output for the coming edge
    always_comb begin
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        dacdat_s  = 1'b0;
        active_s  = 1'b0;
        if (start_s) begin
            dacdat_s  = word_s[WIDTH-1];
            shift_s   = {word_s[WIDTH-2:0], 1'b0};
            bit_cnt_s = {{(BCNT_W-1){1'b0}}, 1'b1};
            active_s  = 1'b1;
        end else if ((state_s == SHIFT_L) || (state_s == SHIFT_R)) begin
            dacdat_s  = shift_r[WIDTH-1];
            shift_s   = {shift_r[WIDTH-2:0], 1'b0};
            bit_cnt_s = bit_cnt_r + {{(BCNT_W-1){1'b0}}, 1'b1};
            active_s  = 1'b1;
        end else begin
            shift_s   = {WIDTH{1'b0}};
            bit_cnt_s = {BCNT_W{1'b0}};
        end
    end

    // Buffer occupancy and saturating underflow count
    always_comb begin
        buf_full_s = buf_full_r;
        uf_cnt_s   = o_underflow_cnt;
        if (take_buf_s) begin
            buf_full_s = 1'b0;
        end else if (write_s) begin
            buf_full_s = 1'b1;
        end else begin
            buf_full_s = buf_full_r;
        end
        if (underflow_s && (o_underflow_cnt != {CNT_W{1'b1}})) begin
            uf_cnt_s = o_underflow_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            uf_cnt_s = o_underflow_cnt;
        end
    end

    // All state and registered outputs update on falling BCLK
    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r         <= IDLE;
            lrc_q_r         <= 1'b0;
            buf_r           <= {WIDTH{1'b0}};
            buf_full_r      <= 1'b0;
            shift_r         <= {WIDTH{1'b0}};
            mono_word_r     <= {WIDTH{1'b0}};
            bit_cnt_r       <= {BCNT_W{1'b0}};
            o_dacdat        <= 1'b0;
            o_active        <= 1'b0;
            o_underflow     <= 1'b0;
            o_underflow_cnt <= {CNT_W{1'b0}};
        end else begin
            state_r         <= state_s;
            lrc_q_r         <= i_lrc;
            buf_full_r      <= buf_full_s;
            shift_r         <= shift_s;
            bit_cnt_r       <= bit_cnt_s;
            o_dacdat        <= dacdat_s;
            o_active        <= active_s;
            o_underflow     <= underflow_s;
            o_underflow_cnt <= uf_cnt_s;
            if (write_s) begin
                buf_r <= i_sample;
            end
            if (start_s && left_start_s) begin
                mono_word_r <= word_s;
            end
        end
    end

endmodule
